instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: PC handoff, instruction memory request/ack, decode-side queue head.
// The master side belongs to the fetch unit; the slave side is the PC, memory and decode environment.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] pc_in;
    logic                  pc_take;
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  flush;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  id_ready;

    modport master (
        input  pc_in, imem_ack, imem_rdata, flush, id_ready,
        output pc_take, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output pc_in, imem_ack, imem_rdata, flush, id_ready,
        input  pc_take, imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request feeding a 2-entry {addr, instr} queue.
// Zero-wait memory gives one instruction per cycle; pc_take stalls when the queue would be full.
module instr_fetch #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t                state, state_nxt;
    logic [1:0]            count, count_post, count_nxt;
    logic                  wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] addr_mem [2];
    logic [DATA_WIDTH-1:0] data_mem [2];
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  push, pop, take;

    // A pop during flush is still a handshake with decode; the flush then empties the queue.
    assign pop        = (count != 2'd0) && bus.id_ready;
    assign push       = (state == WAIT) && bus.imem_ack && !bus.flush;
    assign count_post = count + 2'(push) - 2'(pop);
    assign count_nxt  = bus.flush ? 2'd0 : count_post;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.flush && count != 2'd2) begin
                    take      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_nxt = bus.imem_ack ? IDLE : DISCARD;
                end else if (bus.imem_ack) begin
                    if (count_post < 2'd2) take = 1'b1;
                    else                   state_nxt = IDLE;
                end
            end
            DISCARD: begin
                // The stale response is consumed on ack, even if another flush arrives with it.
                if (bus.imem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) take = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            req_addr <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (bus.flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
            if (take) req_addr <= bus.pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem[wr_ptr] <= req_addr;
            data_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.pc_take   = take;
    assign bus.imem_req  = (state != IDLE);
    assign bus.imem_addr = req_addr;
    assign bus.if_valid  = (count != 2'd0);
    assign bus.if_instr  = data_mem[rd_ptr];
    assign bus.if_pc     = addr_mem[rd_ptr];
endmodule

// File: tb/tb_instr_fetch.sv
// Directed scenarios then random traffic, each cycle checked against a queue-based reference model.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();
    instr_fetch #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference model: the instruction queue plus the single outstanding request.
    logic [11:0] mq_pc [$];
    logic [15:0] mq_ins [$];
    bit          m_busy = 1'b0;
    bit          m_drop = 1'b0;
    logic [11:0] m_addr = 12'h000;
    logic [11:0] pc     = 12'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit ack, input bit idr, input logic [15:0] data);
        bit t, pop;
        int sz;
        reset = rst; bus.flush = fl; bus.imem_ack = ack; bus.id_ready = idr;
        bus.pc_in = pc; bus.imem_rdata = data;
        #3;
        sz  = mq_pc.size();
        pop = (sz != 0) && idr;
        if (rst || fl)              t = 1'b0;
        else if (!m_busy)           t = (sz < 2);
        else if (m_drop || !ack)    t = 1'b0;
        else                        t = ((sz + 1 - int'(pop)) < 2);
        chk("pc_take",   32'(bus.pc_take),   32'(t));
        chk("imem_req",  32'(bus.imem_req),  32'(m_busy));
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
        chk("if_valid",  32'(bus.if_valid),  32'(sz != 0));
        if (sz != 0) begin
            chk("if_pc",    32'(bus.if_pc),    32'(mq_pc[0]));
            chk("if_instr", 32'(bus.if_instr), 32'(mq_ins[0]));
        end
        @(posedge clk);
        if (rst) begin
            mq_pc.delete(); mq_ins.delete();
            m_busy = 1'b0; m_drop = 1'b0; m_addr = 12'h000;
        end else begin
            if (pop) begin
                void'(mq_pc.pop_front()); void'(mq_ins.pop_front());
            end
            if (m_busy && ack) begin
                if (!m_drop && !fl) begin
                    mq_pc.push_back(m_addr); mq_ins.push_back(data);
                end
                m_busy = 1'b0; m_drop = 1'b0;
            end else if (m_busy && fl) begin
                m_drop = 1'b1;
            end
            if (fl) begin
                mq_pc.delete(); mq_ins.delete();
            end
            if (t) begin
                m_busy = 1'b1; m_addr = pc; pc = pc + 12'd1;
            end
        end
        #1;
    endtask

    initial begin
        logic [11:0] held;
        reset = 1'b1; bus.flush = 1'b0; bus.imem_ack = 1'b0; bus.id_ready = 1'b0;
        bus.pc_in = '0; bus.imem_rdata = '0;
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);

        // Streaming with zero-wait memory and decode always ready.
        pc = 12'h000;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, m_busy, 1, 16'hA000 + 16'(m_addr));
            if (k >= 1) begin
                chk("seq_valid", 32'(bus.if_valid), 32'd1);
                chk("seq_pc",    32'(bus.if_pc),    32'(k - 1));
                chk("seq_instr", 32'(bus.if_instr), 32'hA000 + 32'(k - 1));
            end
        end

        // Decode stalled: queue fills to two, requests stop.
        for (int k = 0; k < 5; k++) step(0, 0, m_busy, 0, 16'hA000 + 16'(m_addr));
        chk("full_req",   32'(bus.imem_req), 32'd0);
        chk("full_valid", 32'(bus.if_valid), 32'd1);
        held = bus.if_pc;
        step(0, 0, 0, 0, 16'h0);
        chk("hold_pc", 32'(bus.if_pc), 32'(held));

        // Single pop releases one new fetch.
        step(0, 0, m_busy, 1, 16'hA000 + 16'(m_addr));
        for (int k = 0; k < 3; k++) step(0, 0, m_busy, 0, 16'hA000 + 16'(m_addr));

        // Drain, then a request whose ack is held off for three cycles.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 16'h0);
        if (!m_busy) step(0, 0, 0, 1, 16'h0);
        held = bus.imem_addr;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 16'h0);
            chk("wait_req",  32'(bus.imem_req),  32'd1);
            chk("wait_addr", 32'(bus.imem_addr), 32'(held));
        end
        step(0, 0, 1, 0, 16'hA000 + 16'(m_addr));
        chk("late_push_pc", 32'(bus.if_pc), 32'(held));

        // Flush with a request in flight; the stale 0xDEAD response is dropped.
        if (!m_busy) step(0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        chk("flush_valid", 32'(bus.if_valid), 32'd0);
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 16'hDEAD);
        chk("dead_valid", 32'(bus.if_valid), 32'd0);
        chk("dead_req",   32'(bus.imem_req), 32'd0);
        pc = 12'h3C0;
        step(0, 0, 0, 1, 16'h0);
        chk("resume_addr", 32'(bus.imem_addr), 32'h3C0);
        step(0, 0, 1, 1, 16'h5A5A);
        chk("resume_pc", 32'(bus.if_pc), 32'h3C0);

        // Reset during WAIT with a same-cycle ack, then a late ack while idle.
        if (!m_busy) step(0, 0, 0, 0, 16'h0);
        step(1, 0, 1, 0, 16'hBEEF);
        chk("rstw_valid", 32'(bus.if_valid), 32'd0);
        chk("rstw_req",   32'(bus.imem_req), 32'd0);
        chk("rstw_addr",  32'(bus.imem_addr), 32'd0);
        step(0, 0, 1, 1, 16'hBEEF);
        step(0, 0, 1, 1, 16'h1234);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            bit r, f, a, d;
            r = ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 9) == 0);
            a = m_busy && ($urandom_range(0, 2) != 0);
            if (!m_busy && $urandom_range(0, 19) == 0) a = 1'b1;
            if (m_drop && a) f = 1'b0;
            d = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) pc = 12'($urandom);
            step(r, f, a, d, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
